// File: rtl/rv_wb_ctrl_pkg.sv
// Shared writeback types and constants.
// Register-file geometry and result source tags.
package rv_pkg;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LSU
   } wb_src_e;
endpackage

// File: rtl/rv_wb_ctrl_if.sv
// Writeback bus bundle: ALU/LSU results in,
// issue marks in, register-file write port and scoreboard out.
interface rv_wb_ctrl_if #(
   parameter int XLEN = 64
);
   logic            alu_valid_i;
   logic [4:0]      alu_rd_i;
   logic [XLEN-1:0] alu_data_i;
   logic            alu_ready_o;
   logic            lsu_valid_i;
   logic            lsu_ready_o;
   logic [4:0]      lsu_rd_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            iss_valid_i;
   logic [4:0]      iss_rd_i;
   logic            rf_wr_en_o;
   logic [4:0]      rf_wr_reg_o;
   logic [XLEN-1:0] rf_wr_data_o;
   logic [31:0]     busy_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      output alu_ready_o,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      output lsu_ready_o,
      input  iss_valid_i, iss_rd_i,
      output rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o,
      output busy_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      input  alu_ready_o,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  lsu_ready_o,
      output iss_valid_i, iss_rd_i,
      input  rf_wr_en_o, rf_wr_reg_o, rf_wr_data_o,
      input  busy_o
   );
endinterface

// File: rtl/rv_wb_fifo.sv
// Small synchronous FIFO holding {rd, data} load results.
// Pointers wrap naturally; depth must be a power of 2.
module rv_wb_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 69
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_i,
   input  logic [W-1:0]               wdata_i,
   input  logic                       pop_i,
   output logic [W-1:0]               rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign rdata_o = mem_q[rd_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next pointer and occupancy values.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count state; reset empties the queue.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/rv_wb_ctrl.sv
// Writeback controller: ALU/LSU arbitration with anti-starvation,
// registered RF write port and load-pending scoreboard.
module rv_wb_ctrl
   import rv_pkg::*;
#(
   parameter int XLEN       = rv_pkg::XLEN,
   parameter int LSU_DEPTH  = 2,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rstn,
   rv_wb_ctrl_if.slave  wb
);
   localparam int SW = $clog2(STARVE_MAX+1);
   localparam int CW = $clog2(LSU_DEPTH+1);
   localparam int EW = 5 + XLEN;

   logic [EW-1:0]   head;
   logic [4:0]      head_rd;
   logic [XLEN-1:0] head_data;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_cnt;
   logic            fifo_nonempty;
   logic            force_lsu, alu_real, alu_win;
   logic            pop, push;

   logic [SW-1:0]   starve_q, starve_d;
   logic            wr_en_q, wr_en_d;
   logic [4:0]      wr_reg_q, wr_reg_d;
   logic [XLEN-1:0] wr_data_q, wr_data_d;
   wb_src_e         src_q, src_d;
   logic [NREG-1:0] busy_q, busy_d;

   rv_wb_fifo #(
      .DEPTH (LSU_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .wdata_i ({wb.lsu_rd_i, wb.lsu_data_i}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   assign head_rd       = head[EW-1 -: 5];
   assign head_data     = head[XLEN-1:0];
   assign fifo_nonempty = (fifo_cnt != '0);

   assign force_lsu = (starve_q == SW'(STARVE_MAX)) && fifo_nonempty;
   assign alu_real  = wb.alu_valid_i && (wb.alu_rd_i != REG_ZERO);
   assign alu_win   = !force_lsu && alu_real;
   // x0 ALU results leave the port free for the FIFO head.
   assign pop       = fifo_nonempty && !alu_win;
   assign push      = wb.lsu_valid_i && !fifo_full;

   assign wb.alu_ready_o  = !force_lsu;
   assign wb.lsu_ready_o  = !fifo_full;
   assign wb.rf_wr_en_o   = wr_en_q;
   assign wb.rf_wr_reg_o  = wr_reg_q;
   assign wb.rf_wr_data_o = wr_data_q;
   assign wb.busy_o       = busy_q;

   // Select the write winner and advance the starve counter.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      src_d     = WB_NONE;
      unique case (1'b1)
         alu_win: begin
            wr_en_d   = 1'b1;
            wr_reg_d  = wb.alu_rd_i;
            wr_data_d = wb.alu_data_i;
            src_d     = WB_ALU;
         end
         (pop && head_rd != REG_ZERO): begin
            wr_en_d   = 1'b1;
            wr_reg_d  = head_rd;
            wr_data_d = head_data;
            src_d     = WB_LSU;
         end
         default: ;
      endcase

      starve_d = starve_q;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (alu_win &&
                   starve_q != SW'(STARVE_MAX)) begin
         starve_d = starve_q + SW'(1);
      end
   end

   // Scoreboard: load writeback clears, new issue sets (set wins).
   always_comb begin
      busy_d = busy_q;
      if (wr_en_q && src_q == WB_LSU) busy_d[wr_reg_q] = 1'b0;
      if (wb.iss_valid_i && wb.iss_rd_i != REG_ZERO) begin
         busy_d[wb.iss_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Registered write port, starve counter and scoreboard.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_en_q   <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         src_q     <= WB_NONE;
         starve_q  <= '0;
         busy_q    <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         src_q     <= src_d;
         starve_q  <= starve_d;
         busy_q    <= busy_d;
      end
   end
endmodule

// File: tb/tb_rv_wb_ctrl.sv
// Bench for rv_wb_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rv_wb_ctrl;
   import rv_pkg::*;

   localparam int XL    = 64;
   localparam int DEPTH = 2;
   localparam int SMAX  = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   rv_wb_ctrl_if #(.XLEN(XL)) wb ();

   rv_wb_ctrl #(
      .XLEN       (XL),
      .LSU_DEPTH  (DEPTH),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .wb   (wb.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] d;
   } ent_t;

   ent_t        mq[$];
   ent_t        h;
   int          m_starve = 0;
   logic [31:0] m_busy   = '0;
   bit          m_en     = 0;
   logic [4:0]  m_reg    = '0;
   logic [63:0] m_data   = '0;
   bit          m_lsu    = 0;
   bit          started  = 0;
   bit          was_empty, frc, take, pp, ps;

   always @(posedge clk) begin
      if (!rstn) begin
         mq.delete();
         m_starve = 0;
         m_busy   = '0;
         m_en     = 0;
         m_reg    = '0;
         m_data   = '0;
         m_lsu    = 0;
         started  = 1;
      end else begin
         was_empty = (mq.size() == 0);
         frc  = (m_starve == SMAX) && !was_empty;
         take = !frc && wb.alu_valid_i && wb.alu_rd_i != 0;
         pp   = !was_empty && !take;
         ps   = wb.lsu_valid_i && (mq.size() < DEPTH);
         if (m_en && m_lsu) m_busy[m_reg] = 1'b0;
         if (wb.iss_valid_i && wb.iss_rd_i != 0)
            m_busy[wb.iss_rd_i] = 1'b1;
         m_en  = 0;
         m_lsu = 0;
         if (take) begin
            m_en   = 1;
            m_reg  = wb.alu_rd_i;
            m_data = wb.alu_data_i;
         end else if (pp) begin
            h = mq.pop_front();
            if (h.rd != 0) begin
               m_en   = 1;
               m_lsu  = 1;
               m_reg  = h.rd;
               m_data = h.d;
            end
         end
         if (pp || was_empty) m_starve = 0;
         else if (take && m_starve < SMAX) m_starve++;
         if (ps) mq.push_back('{wb.lsu_rd_i, wb.lsu_data_i});
      end
   end

   // Compare DUT against the model every cycle after reset.
   always @(negedge clk) begin
      if (started) begin
         chk("m_wr_en", 64'(wb.rf_wr_en_o), 64'(m_en));
         chk("m_wr_reg", 64'(wb.rf_wr_reg_o), 64'(m_reg));
         chk("m_wr_data", wb.rf_wr_data_o, m_data);
         chk("m_busy", 64'(wb.busy_o), 64'(m_busy));
         chk("m_alu_rdy", 64'(wb.alu_ready_o),
             64'(!(m_starve == SMAX && mq.size() > 0)));
         chk("m_lsu_rdy", 64'(wb.lsu_ready_o),
             64'(mq.size() < DEPTH));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      wb.alu_valid_i = 1'b0;
      wb.alu_rd_i    = '0;
      wb.alu_data_i  = '0;
      wb.lsu_valid_i = 1'b0;
      wb.lsu_rd_i    = '0;
      wb.lsu_data_i  = '0;
      wb.iss_valid_i = 1'b0;
      wb.iss_rd_i    = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic r;
   int   adv, lowcyc, lowcnt, np, stall, acc3;

   initial begin
      idle();
      rstn = 1'b0;
      repeat (2) cyc();
      rstn = 1'b1;
      chk("rst_en", 64'(wb.rf_wr_en_o), 64'd0);
      chk("rst_reg", 64'(wb.rf_wr_reg_o), 64'd0);
      chk("rst_data", wb.rf_wr_data_o, 64'd0);
      chk("rst_busy", 64'(wb.busy_o), 64'd0);
      chk("rst_lsu_rdy", 64'(wb.lsu_ready_o), 64'd1);
      cyc();

      // 1: single ALU write
      wb.alu_valid_i = 1'b1;
      wb.alu_rd_i    = 5'd5;
      wb.alu_data_i  = 64'h1234;
      cyc();
      idle();
      chk("t1_en", 64'(wb.rf_wr_en_o), 64'd1);
      chk("t1_reg", 64'(wb.rf_wr_reg_o), 64'd5);
      chk("t1_data", wb.rf_wr_data_o, 64'h1234);

      // 2: load issue, LSU return, busy clear
      wb.iss_valid_i = 1'b1;
      wb.iss_rd_i    = 5'd7;
      cyc();
      idle();
      chk("t2_busy_set", 64'(wb.busy_o[7]), 64'd1);
      wb.lsu_valid_i = 1'b1;
      wb.lsu_rd_i    = 5'd7;
      wb.lsu_data_i  = 64'hAA;
      cyc();
      idle();
      chk("t2_p1_en", 64'(wb.rf_wr_en_o), 64'd0);
      cyc();
      chk("t2_p2_en", 64'(wb.rf_wr_en_o), 64'd1);
      chk("t2_p2_reg", 64'(wb.rf_wr_reg_o), 64'd7);
      chk("t2_p2_data", wb.rf_wr_data_o, 64'hAA);
      chk("t2_p2_busy", 64'(wb.busy_o[7]), 64'd1);
      cyc();
      chk("t2_p3_busy", 64'(wb.busy_o[7]), 64'd0);
      chk("t2_p3_en", 64'(wb.rf_wr_en_o), 64'd0);

      // 3: starvation forcing
      adv = 1;
      lowcyc = -1;
      lowcnt = 0;
      for (int i = 0; i < 8; i++) begin
         wb.alu_valid_i = 1'b1;
         wb.alu_rd_i    = 5'(adv);
         wb.alu_data_i  = 64'(100 + adv);
         if (i == 0) begin
            wb.lsu_valid_i = 1'b1;
            wb.lsu_rd_i    = 5'd11;
            wb.lsu_data_i  = 64'hBB;
         end else begin
            wb.lsu_valid_i = 1'b0;
         end
         @(negedge clk);
         r = wb.alu_ready_o;
         if (!r) begin
            lowcnt++;
            if (lowcyc < 0) lowcyc = i;
         end
         cyc();
         if (r) adv++;
         if (i == 5) begin
            chk("t3_lsu_reg", 64'(wb.rf_wr_reg_o), 64'd11);
            chk("t3_lsu_data", wb.rf_wr_data_o, 64'hBB);
         end
         if (i == 6) begin
            chk("t3_resume_reg", 64'(wb.rf_wr_reg_o), 64'd6);
            chk("t3_resume_data", wb.rf_wr_data_o, 64'd106);
         end
      end
      idle();
      chk("t3_low_cycle", 64'(lowcyc), 64'd5);
      chk("t3_low_count", 64'(lowcnt), 64'd1);
      cyc();

      // 4: FIFO fill and stalled third push
      np = 0;
      stall = -1;
      acc3 = -1;
      for (int i = 0; i < 8; i++) begin
         wb.alu_valid_i = 1'b1;
         wb.alu_rd_i    = 5'd1;
         wb.alu_data_i  = 64'd7;
         if (np < 3) begin
            wb.lsu_valid_i = 1'b1;
            wb.lsu_rd_i    = 5'(20 + np);
            wb.lsu_data_i  = 64'(16 + np);
         end else begin
            wb.lsu_valid_i = 1'b0;
         end
         @(negedge clk);
         r = wb.lsu_ready_o;
         if (np < 3 && !r && stall < 0) stall = i;
         cyc();
         if (np < 3 && r) begin
            if (np == 2) acc3 = i;
            np++;
         end
      end
      idle();
      chk("t4_stall_cycle", 64'(stall), 64'd2);
      chk("t4_third_push", 64'(acc3), 64'd6);
      repeat (4) cyc();
      chk("t4_drained", 64'(wb.lsu_ready_o), 64'd1);

      // 5: ALU x0 frees the port for a queued load
      wb.alu_valid_i = 1'b1;
      wb.alu_rd_i    = 5'd1;
      wb.alu_data_i  = 64'h77;
      wb.lsu_valid_i = 1'b1;
      wb.lsu_rd_i    = 5'd3;
      wb.lsu_data_i  = 64'h33;
      cyc();
      chk("t5_alu_reg", 64'(wb.rf_wr_reg_o), 64'd1);
      wb.alu_rd_i    = 5'd0;
      wb.alu_data_i  = 64'h55;
      wb.lsu_valid_i = 1'b0;
      wb.iss_valid_i = 1'b1;
      wb.iss_rd_i    = 5'd0;
      cyc();
      idle();
      chk("t5_en", 64'(wb.rf_wr_en_o), 64'd1);
      chk("t5_reg", 64'(wb.rf_wr_reg_o), 64'd3);
      chk("t5_data", wb.rf_wr_data_o, 64'h33);
      chk("t5_busy0", 64'(wb.busy_o[0]), 64'd0);
      cyc();

      // 6: reset with queued loads and pending busy
      wb.alu_valid_i = 1'b1;
      wb.alu_rd_i    = 5'd1;
      wb.alu_data_i  = 64'h1;
      wb.iss_valid_i = 1'b1;
      wb.iss_rd_i    = 5'd9;
      wb.lsu_valid_i = 1'b1;
      wb.lsu_rd_i    = 5'd9;
      wb.lsu_data_i  = 64'h99;
      cyc();
      chk("t6_busy9", 64'(wb.busy_o[9]), 64'd1);
      wb.iss_valid_i = 1'b0;
      wb.lsu_rd_i    = 5'd12;
      wb.lsu_data_i  = 64'hC;
      cyc();
      idle();
      rstn = 1'b0;
      @(negedge clk);
      chk("t6_full", 64'(wb.lsu_ready_o), 64'd0);
      cyc();
      chk("t6_rst_en", 64'(wb.rf_wr_en_o), 64'd0);
      chk("t6_rst_reg", 64'(wb.rf_wr_reg_o), 64'd0);
      chk("t6_rst_data", wb.rf_wr_data_o, 64'd0);
      chk("t6_rst_busy", 64'(wb.busy_o), 64'd0);
      chk("t6_rst_rdy", 64'(wb.lsu_ready_o), 64'd1);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t6_no_stale", 64'(wb.rf_wr_en_o), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
